// File: rtl/stv_arb_pkg.sv
// -----------------------------------------------------------------------------
// stv_arb_pkg
// Shared types and helpers for the stv round-robin arbitration blocks.
//   arb_state_e : arbiter grant state (idle / held under stall / packet-locked)
//   rr_next     : wrapping increment idx -> idx+1, with n-1 -> 0. The wrap
//                 compares against n-1 explicitly, so it also works when n is
//                 not a power of two.
// -----------------------------------------------------------------------------
package stv_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_HOLD   = 2'd1,
      ARB_LOCKED = 2'd2
   } arb_state_e;

   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx == n - 32'd1) ? 32'd0 : idx + 32'd1;
   endfunction

endpackage

// File: rtl/stv_rr_pick.sv
// -----------------------------------------------------------------------------
// stv_rr_pick
// Purely combinational rotating-priority picker. It returns the first set
// request found when searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
//   req [N]   : request vector
//   ptr [IDW] : highest-priority index for this search (must be < N)
//   sel [IDW] : chosen index, 0 when no request is set
//   any       : at least one request is set
// -----------------------------------------------------------------------------
module stv_rr_pick
   import stv_arb_pkg::*;
#(
   parameter  int N   = 4,
   localparam int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [IDW-1:0] sel,
   output logic           any
);

   always_comb begin
      logic [IDW-1:0] idx;
      sel = '0;
      any = 1'b0;
      idx = ptr;
      // Walk the ring once starting at ptr; the first hit wins.
      for (int k = 0; k < N; k++) begin
         if (!any && req[idx]) begin
            any = 1'b1;
            sel = idx;
         end
         idx = IDW'(rr_next(32'(idx), unsigned'(N)));
      end
   end

endmodule

// File: rtl/stv_rr_arb.sv
// -----------------------------------------------------------------------------
// stv_rr_arb
// N-way round-robin arbiter that shares one downstream ready/valid port
// between N requesters. The winner's beat is muxed to the output and tagged
// with its requester index. A grant is frozen while the output is stalled.
//
// Optional feature (macro STV_RR_ARB_PKT_LOCK_EN):
//   defined   : packet lock -- once a beat with last=0 is accepted, the grant
//               stays with that requester until its last=1 beat is accepted,
//               even across valid gaps.
//   undefined : re-arbitration after every accepted beat; in_last is only
//               passed through to out_last.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_valid  [N]     : per-requester valid
//   in_ready  [N]     : per-requester ready, at most one bit set
//   in_data   [N*W]   : requester i at bits [i*WIDTH +: WIDTH]
//   in_last   [N]     : per-requester end-of-packet
//   out_valid/out_ready/out_data/out_last : downstream channel
//   out_id    [IDW]   : index of the requester driving the output
//   busy              : grant held (state not idle)
// -----------------------------------------------------------------------------
module stv_rr_arb
   import stv_arb_pkg::*;
#(
   parameter  int N     = 4,
   parameter  int WIDTH = 32,
   localparam int IDW   = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_last,
   output logic [IDW-1:0]     out_id,
   output logic               busy
);

`ifdef STV_RR_ARB_PKT_LOCK_EN
   localparam bit PKT_LOCK = 1'b1;
`else
   localparam bit PKT_LOCK = 1'b0;
`endif

   arb_state_e     state_q;
   logic [IDW-1:0] gnt_q;
   logic [IDW-1:0] ptr_q;

   logic [IDW-1:0] pick_sel;
   logic           pick_any;
   logic [IDW-1:0] sel;
   logic [IDW-1:0] ptr_nxt;
   logic           accept;

   stv_rr_pick #(.N(N)) u_pick (
      .req (in_valid),
      .ptr (ptr_q),
      .sel (pick_sel),
      .any (pick_any)
   );

   // In IDLE the picker decides; otherwise the frozen grant drives the mux.
   assign sel     = (state_q == ARB_IDLE) ? pick_sel : gnt_q;
   assign ptr_nxt = IDW'(rr_next(32'(sel), unsigned'(N)));

   always_comb begin
      out_valid = 1'b0;
      if (!rst) begin
         out_valid = (state_q == ARB_IDLE) ? pick_any : in_valid[sel];
      end
   end

   assign out_data = in_data[int'(sel) * WIDTH +: WIDTH];
   assign out_last = in_last[sel];
   assign out_id   = sel;
   assign accept   = out_valid && out_ready;
   assign busy     = (state_q != ARB_IDLE);

   always_comb begin
      in_ready      = '0;
      in_ready[sel] = accept;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         gnt_q   <= '0;
         ptr_q   <= '0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (out_valid) begin
                  if (!accept) begin
                     // Freeze the grant so out_id/out_data cannot move under stall.
                     gnt_q   <= sel;
                     state_q <= ARB_HOLD;
                  end else if (PKT_LOCK && !out_last) begin
                     gnt_q   <= sel;
                     state_q <= ARB_LOCKED;
                  end else begin
                     ptr_q <= ptr_nxt;
                  end
               end
            end
            ARB_HOLD: begin
               if (accept) begin
                  if (PKT_LOCK && !out_last) begin
                     state_q <= ARB_LOCKED;
                  end else begin
                     ptr_q   <= ptr_nxt;
                     state_q <= ARB_IDLE;
                  end
               end
            end
            ARB_LOCKED: begin
               // Valid gaps keep the lock; only the accepted last beat releases it.
               if (accept && out_last) begin
                  ptr_q   <= ptr_nxt;
                  state_q <= ARB_IDLE;
               end
            end
            default: begin
               state_q <= ARB_IDLE;
            end
         endcase
      end
   end

endmodule
